// File: rtl/id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// id_stage_pipelined
// Decode stage of the MIPS pipeline, between the IF/ID register and EX.
// Decodes the opcode (main control plus sign extender), reads a NUM_REGS-entry
// register bank, detects load-use / branch-operand / write-back hazards,
// resolves branches in ID and launches every EX-bound field through an
// internal ID/EX register. Bubbles are inserted on stall, flush or idle.
// A halt instruction makes o_halt sticky until reset.
//
// Optional feature macro: ID_WB_BYPASS_EN
//   defined   : a same-cycle write-back to the register being read is
//               forwarded into ID, so no write-back hazard exists.
//   undefined : reads return the pre-write bank value and a write-back
//               collision stalls ID for one cycle.
//
// Ports
//   i_clock, i_reset (async, active low)
//   i_valid, i_instruccion, i_currentpc, i_flush      IF/ID side
//   i_ex_memread, i_ex_regwrite, i_ex_rd               EX-stage writer
//   i_mem_regwrite, i_mem_rd                           MEM-stage writer
//   i_regwrite, i_rt_rd, i_writedata                   write-back port
//   o_ready, o_branch, o_pcbranch                      combinational
//   o_valid, o_regA, o_regB, o_extendido, o_opcode,
//   o_rs, o_rt, o_rd, o_ex, o_mem, o_wb, o_halt        registered
//
// Control encoding: o_ex = {regdst, alusrc, aluop[1:0]},
//                   o_mem = {branch, memread, memwrite},
//                   o_wb = {regwrite, memtoreg}.
// -----------------------------------------------------------------------------
module id_stage_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZEOP     = 6,
  parameter int NUM_REGS   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_instruccion,
  input  logic [DATA_WIDTH-1:0] i_currentpc,
  input  logic                  i_flush,
  input  logic                  i_ex_memread,
  input  logic                  i_ex_regwrite,
  input  logic [4:0]            i_ex_rd,
  input  logic                  i_mem_regwrite,
  input  logic [4:0]            i_mem_rd,
  input  logic                  i_regwrite,
  input  logic [4:0]            i_rt_rd,
  input  logic [DATA_WIDTH-1:0] i_writedata,
  output logic                  o_ready,
  output logic                  o_branch,
  output logic [DATA_WIDTH-1:0] o_pcbranch,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_regA,
  output logic [DATA_WIDTH-1:0] o_regB,
  output logic [DATA_WIDTH-1:0] o_extendido,
  output logic [SIZEOP-1:0]     o_opcode,
  output logic [4:0]            o_rs,
  output logic [4:0]            o_rt,
  output logic [4:0]            o_rd,
  output logic [3:0]            o_ex,
  output logic [2:0]            o_mem,
  output logic [1:0]            o_wb,
  output logic                  o_halt
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0]     IDX_ZERO = '0;
  localparam logic [SIZEOP-1:0] OP_RTYPE = SIZEOP'(6'h00);
  localparam logic [SIZEOP-1:0] OP_BEQ   = SIZEOP'(6'h04);
  localparam logic [SIZEOP-1:0] OP_BNE   = SIZEOP'(6'h05);
  localparam logic [SIZEOP-1:0] OP_ADDI  = SIZEOP'(6'h08);
  localparam logic [SIZEOP-1:0] OP_LW    = SIZEOP'(6'h23);
  localparam logic [SIZEOP-1:0] OP_SW    = SIZEOP'(6'h2B);
  localparam logic [SIZEOP-1:0] OP_HALT  = SIZEOP'(6'h3F);

  logic [DATA_WIDTH-1:0] r_bank [NUM_REGS];
  logic                  r_valid, r_halt;
  logic [DATA_WIDTH-1:0] r_rega, r_regb, r_ext;
  logic [SIZEOP-1:0]     r_opcode;
  logic [4:0]            r_rs, r_rt, r_rd;
  logic [3:0]            r_ex;
  logic [2:0]            r_mem;
  logic [1:0]            r_wb;

  logic [SIZEOP-1:0]     w_op;
  logic [4:0]            w_rs, w_rt, w_rd;
  logic [DATA_WIDTH-1:0] w_ext, w_bank_a, w_bank_b, w_opa, w_opb;
  logic [IW-1:0]         w_rs_idx, w_rt_idx, w_wr_idx;
  logic [3:0]            w_ex;
  logic [2:0]            w_mem;
  logic [1:0]            w_wb;
  logic                  w_use_rt, w_is_branch, w_is_beq, w_is_halt;
  logic                  w_wb_active, w_wb_hazard, w_load_use, w_ex_hit, w_mem_hit;
  logic                  w_br_hazard, w_stall, w_go, w_taken;

  assign w_op     = SIZEOP'(i_instruccion[31:26]);
  assign w_rs     = i_instruccion[25:21];
  assign w_rt     = i_instruccion[20:16];
  assign w_rd     = i_instruccion[15:11];
  assign w_ext    = {{(DATA_WIDTH-16){i_instruccion[15]}}, i_instruccion[15:0]};
  assign w_rs_idx = w_rs[IW-1:0];
  assign w_rt_idx = w_rt[IW-1:0];
  assign w_wr_idx = i_rt_rd[IW-1:0];

  // Main control: opcode to EX/MEM/WB control bits and hazard qualifiers
  always_comb begin
    w_ex        = 4'b0000;
    w_mem       = 3'b000;
    w_wb        = 2'b00;
    w_use_rt    = 1'b0;
    w_is_branch = 1'b0;
    w_is_beq    = 1'b0;
    w_is_halt   = 1'b0;
    case (w_op)
      OP_RTYPE: begin w_ex = 4'b1010; w_wb = 2'b10; w_use_rt = 1'b1; end
      OP_LW:    begin w_ex = 4'b0100; w_mem = 3'b010; w_wb = 2'b11; end
      OP_SW:    begin w_ex = 4'b0100; w_mem = 3'b001; w_use_rt = 1'b1; end
      OP_BEQ:   begin w_ex = 4'b0001; w_mem = 3'b100; w_use_rt = 1'b1;
                      w_is_branch = 1'b1; w_is_beq = 1'b1; end
      OP_BNE:   begin w_ex = 4'b0001; w_mem = 3'b100; w_use_rt = 1'b1;
                      w_is_branch = 1'b1; end
      OP_ADDI:  begin w_ex = 4'b0100; w_wb = 2'b10; end
      OP_HALT:  begin w_is_halt = 1'b1; end
      default:  begin w_ex = 4'b0000; end
    endcase
  end

  // Register 0 is hard-wired to zero regardless of what was written to it.
  assign w_bank_a    = (w_rs_idx == IDX_ZERO) ? '0 : r_bank[w_rs_idx];
  assign w_bank_b    = (w_rt_idx == IDX_ZERO) ? '0 : r_bank[w_rt_idx];
  assign w_wb_active = i_regwrite && (i_rt_rd != 5'd0);

  // Operand read: optional write-back forwarding, or a WB collision hazard
  always_comb begin
    w_opa       = w_bank_a;
    w_opb       = w_bank_b;
    w_wb_hazard = 1'b0;
`ifdef ID_WB_BYPASS_EN
    // Forward on bank-index match so aliasing follows the bank's own folding.
    if (w_wb_active && (w_wr_idx == w_rs_idx) && (w_rs_idx != IDX_ZERO)) begin
      w_opa = i_writedata;
    end else begin
      w_opa = w_bank_a;
    end
    if (w_wb_active && (w_wr_idx == w_rt_idx) && (w_rt_idx != IDX_ZERO)) begin
      w_opb = i_writedata;
    end else begin
      w_opb = w_bank_b;
    end
`else
    w_wb_hazard = w_wb_active && ((i_rt_rd == w_rs) || (w_use_rt && (i_rt_rd == w_rt)));
`endif
  end

  assign w_load_use  = i_ex_memread && (i_ex_rd != 5'd0) &&
                       ((i_ex_rd == w_rs) || (w_use_rt && (i_ex_rd == w_rt)));
  assign w_ex_hit    = i_ex_regwrite && (i_ex_rd != 5'd0) &&
                       ((i_ex_rd == w_rs) || (i_ex_rd == w_rt));
  assign w_mem_hit   = i_mem_regwrite && (i_mem_rd != 5'd0) &&
                       ((i_mem_rd == w_rs) || (i_mem_rd == w_rt));
  assign w_br_hazard = w_is_branch && (w_ex_hit || w_mem_hit);
  assign w_stall     = i_valid && !r_halt && (w_load_use || w_br_hazard || w_wb_hazard);
  // w_go: the instruction in ID actually advances this cycle.
  assign w_go        = i_valid && !i_flush && !w_stall && !r_halt;
  assign w_taken     = w_is_beq ? (w_opa == w_opb) : (w_opa != w_opb);

  assign o_ready     = !w_stall && !r_halt;
  assign o_branch    = w_go && w_is_branch && w_taken;
  assign o_pcbranch  = i_currentpc + (w_ext << 2);

  // Register bank write port
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_wb_active) begin
      r_bank[w_wr_idx] <= i_writedata;
    end
  end

  // ID/EX register: load on advance, otherwise bubble (data held); sticky halt
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_valid  <= 1'b0;
      r_halt   <= 1'b0;
      r_rega   <= '0;
      r_regb   <= '0;
      r_ext    <= '0;
      r_opcode <= '0;
      r_rs     <= 5'd0;
      r_rt     <= 5'd0;
      r_rd     <= 5'd0;
      r_ex     <= 4'b0000;
      r_mem    <= 3'b000;
      r_wb     <= 2'b00;
    end else begin
      r_halt <= r_halt || (w_go && w_is_halt);
      if (w_go && !w_is_halt) begin
        r_valid  <= 1'b1;
        r_rega   <= w_opa;
        r_regb   <= w_opb;
        r_ext    <= w_ext;
        r_opcode <= w_op;
        r_rs     <= w_rs;
        r_rt     <= w_rt;
        r_rd     <= w_rd;
        r_ex     <= w_ex;
        r_mem    <= w_mem;
        r_wb     <= w_wb;
      end else begin
        r_valid  <= 1'b0;
        r_ex     <= 4'b0000;
        r_mem    <= 3'b000;
        r_wb     <= 2'b00;
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_halt      = r_halt;
  assign o_regA      = r_rega;
  assign o_regB      = r_regb;
  assign o_extendido = r_ext;
  assign o_opcode    = r_opcode;
  assign o_rs        = r_rs;
  assign o_rt        = r_rt;
  assign o_rd        = r_rd;
  assign o_ex        = r_ex;
  assign o_mem       = r_mem;
  assign o_wb        = r_wb;

endmodule

// File: tb/tb_id_stage_pipelined.sv
`timescale 1ns/1ps
// Scoreboard bench for id_stage_pipelined: a 32-register and an 8-register
// instance share the same stimulus; a rule-level model predicts each issue.
module tb_id_stage_pipelined;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid, flush, exmr, exrw, memrw, rw;
  logic [31:0] ins, pc, wd;
  logic [4:0] exrd, memrd, rtrd;

  logic a_ready, a_branch, a_valid, a_halt;
  logic [31:0] a_pcb, a_ra, a_rb, a_ext;
  logic [5:0] a_op;
  logic [4:0] a_rs, a_rt, a_rd;
  logic [3:0] a_ex;
  logic [2:0] a_mem;
  logic [1:0] a_wb;
  logic b_ready, b_branch, b_valid, b_halt;
  logic [31:0] b_pcb, b_ra, b_rb, b_ext;
  logic [5:0] b_op;
  logic [4:0] b_rs, b_rt, b_rd;
  logic [3:0] b_ex;
  logic [2:0] b_mem;
  logic [1:0] b_wb;

  always #5 clk = ~clk;

  id_stage_pipelined #(.DATA_WIDTH(32), .SIZEOP(6), .NUM_REGS(32)) u32 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_instruccion(ins),
    .i_currentpc(pc), .i_flush(flush), .i_ex_memread(exmr), .i_ex_regwrite(exrw),
    .i_ex_rd(exrd), .i_mem_regwrite(memrw), .i_mem_rd(memrd), .i_regwrite(rw),
    .i_rt_rd(rtrd), .i_writedata(wd), .o_ready(a_ready), .o_branch(a_branch),
    .o_pcbranch(a_pcb), .o_valid(a_valid), .o_regA(a_ra), .o_regB(a_rb),
    .o_extendido(a_ext), .o_opcode(a_op), .o_rs(a_rs), .o_rt(a_rt), .o_rd(a_rd),
    .o_ex(a_ex), .o_mem(a_mem), .o_wb(a_wb), .o_halt(a_halt));

  id_stage_pipelined #(.DATA_WIDTH(32), .SIZEOP(6), .NUM_REGS(8)) u8 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_instruccion(ins),
    .i_currentpc(pc), .i_flush(flush), .i_ex_memread(exmr), .i_ex_regwrite(exrw),
    .i_ex_rd(exrd), .i_mem_regwrite(memrw), .i_mem_rd(memrd), .i_regwrite(rw),
    .i_rt_rd(rtrd), .i_writedata(wd), .o_ready(b_ready), .o_branch(b_branch),
    .o_pcbranch(b_pcb), .o_valid(b_valid), .o_regA(b_ra), .o_regB(b_rb),
    .o_extendido(b_ext), .o_opcode(b_op), .o_rs(b_rs), .o_rt(b_rt), .o_rd(b_rd),
    .o_ex(b_ex), .o_mem(b_mem), .o_wb(b_wb), .o_halt(b_halt));

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] ext;
    logic [8:0]  ctl;
    logic [31:0] ra0, rb0, ra1, rb1;
  } exp_t;

  exp_t q[$];
  logic [31:0] mb0 [32];
  logic [31:0] mb1 [8];
  bit mhalt;
  bit last_ready;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value the bank of instance k (0: 32 regs, 1: 8 regs) presents for field r.
  function automatic logic [31:0] mread(int k, logic [4:0] r);
    int nr, idx;
    nr  = (k == 0) ? 32 : 8;
    idx = int'(r) % nr;
    if (idx == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (rw && rtrd != 5'd0 && (int'(rtrd) % nr) == idx) return wd;
`endif
    return (k == 0) ? mb0[idx] : mb1[idx];
  endfunction

  function automatic logic [31:0] rtype(logic [4:0] s, logic [4:0] t, logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [7];
    logic [4:0] s, t, d;
    logic [15:0] imm;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
    ops[4] = 6'h05; ops[5] = 6'h08; ops[6] = 6'h0F;
    s   = 5'($urandom_range(0, 11));
    t   = 5'($urandom_range(0, 11));
    d   = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    if ($urandom_range(0, 6) == 0) return rtype(s, t, d);
    return itype(ops[$urandom_range(0, 6)], s, t, imm);
  endfunction

  task automatic defaults();
    valid = 1'b0; ins = 32'h0; pc = 32'h0; flush = 1'b0;
    exmr = 1'b0; exrw = 1'b0; exrd = 5'd0; memrw = 1'b0; memrd = 5'd0;
    rw = 1'b0; rtrd = 5'd0; wd = 32'h0;
  endtask

  // One ID cycle: inputs already applied at the preceding negedge.
  task automatic cycle();
    exp_t e;
    bit is_r, lw, sw, br, ad, hl, use_rt, lu, bh, wbh, stall, go, rdy, tk0, tk1;
    logic [31:0] tgt;
    #2;
    e.op = ins[31:26]; e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11];
    e.ext = {{16{ins[15]}}, ins[15:0]};
    is_r = (e.op == 6'h00); lw = (e.op == 6'h23); sw = (e.op == 6'h2B);
    br = (e.op == 6'h04) || (e.op == 6'h05); ad = (e.op == 6'h08); hl = (e.op == 6'h3F);
    use_rt = is_r || sw || br;
    e.ctl = {is_r, lw || sw || ad, is_r, br, br, lw, sw, is_r || lw || ad, lw};
    e.ra0 = mread(0, e.rs); e.rb0 = mread(0, e.rt);
    e.ra1 = mread(1, e.rs); e.rb1 = mread(1, e.rt);
    lu = exmr && exrd != 5'd0 && (exrd == e.rs || (use_rt && exrd == e.rt));
    bh = br && ((exrw && exrd != 5'd0 && (exrd == e.rs || exrd == e.rt)) ||
                (memrw && memrd != 5'd0 && (memrd == e.rs || memrd == e.rt)));
`ifdef ID_WB_BYPASS_EN
    wbh = 1'b0;
`else
    wbh = rw && rtrd != 5'd0 && (rtrd == e.rs || (use_rt && rtrd == e.rt));
`endif
    stall = valid && !mhalt && (lu || bh || wbh);
    go    = valid && !flush && !stall && !mhalt;
    rdy   = !stall && !mhalt;
    tk0   = go && br && ((e.op == 6'h04) ? (e.ra0 == e.rb0) : (e.ra0 != e.rb0));
    tk1   = go && br && ((e.op == 6'h04) ? (e.ra1 == e.rb1) : (e.ra1 != e.rb1));
    tgt   = pc + (e.ext * 32'd4);
    chk("ready32", 32'(a_ready), 32'(rdy));
    chk("ready8", 32'(b_ready), 32'(rdy));
    chk("branch32", 32'(a_branch), 32'(tk0));
    chk("branch8", 32'(b_branch), 32'(tk1));
    chk("pcbranch32", a_pcb, tgt);
    chk("pcbranch8", b_pcb, tgt);
    chk("halt32", 32'(a_halt), 32'(mhalt));
    chk("halt8", 32'(b_halt), 32'(mhalt));
    if (go && !hl) q.push_back(e);
    if (go && hl) mhalt = 1'b1;
    if (rw && rtrd != 5'd0) begin
      mb0[int'(rtrd) % 32] = wd;
      mb1[int'(rtrd) % 8]  = wd;
    end
    last_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    defaults();
    #2;
    chk("rst_ctl32", 32'({a_valid, a_halt, a_ex, a_mem, a_wb}), 32'h0);
    chk("rst_ctl8", 32'({b_valid, b_halt, b_ex, b_mem, b_wb}), 32'h0);
    chk("rst_fields32", 32'({a_op, a_rs, a_rt, a_rd}), 32'h0);
    chk("rst_fields8", 32'({b_op, b_rs, b_rt, b_rd}), 32'h0);
    chk("rst_data32", a_ra | a_rb | a_ext, 32'h0);
    chk("rst_data8", b_ra | b_rb | b_ext, 32'h0);
    chk("rst_ready32", 32'(a_ready), 32'h1);
    chk("rst_ready8", 32'(b_ready), 32'h1);
    chk("rst_queue_drained", 32'(q.size()), 32'h0);
    q.delete();
    for (int i = 0; i < 32; i++) mb0[i] = 32'h0;
    for (int i = 0; i < 8; i++) mb1[i] = 32'h0;
    mhalt = 1'b0;
    last_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wbw(input logic [4:0] r, input logic [31:0] v);
    defaults(); rw = 1'b1; rtrd = r; wd = v;
    cycle();
  endtask

  // Monitor: whenever an instance presents a valid ID/EX slot, pop and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (a_valid || b_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'({a_valid, b_valid}), 32'h0);
      end else begin
        e = q.pop_front();
        chk("valid32", 32'(a_valid), 32'h1);
        chk("valid8", 32'(b_valid), 32'h1);
        chk("fields32", 32'({a_op, a_rs, a_rt, a_rd}), 32'({e.op, e.rs, e.rt, e.rd}));
        chk("fields8", 32'({b_op, b_rs, b_rt, b_rd}), 32'({e.op, e.rs, e.rt, e.rd}));
        chk("ctl32", 32'({a_ex, a_mem, a_wb}), 32'(e.ctl));
        chk("ctl8", 32'({b_ex, b_mem, b_wb}), 32'(e.ctl));
        chk("ext32", a_ext, e.ext);
        chk("ext8", b_ext, e.ext);
        chk("regA32", a_ra, e.ra0);
        chk("regB32", a_rb, e.rb0);
        chk("regA8", b_ra, e.ra1);
        chk("regB8", b_rb, e.rb1);
      end
    end else begin
      chk("bubble_ctl32", 32'({a_ex, a_mem, a_wb}), 32'h0);
      chk("bubble_ctl8", 32'({b_ex, b_mem, b_wb}), 32'h0);
    end
  end

  initial begin
    logic [31:0] cur_ins, cur_pc;
    bit held;
    defaults();
    #1;
    do_reset();

    // Every register reads zero after reset.
    for (int k = 1; k < 32; k++) begin
      defaults(); valid = 1'b1; ins = rtype(5'(k), 5'(k), 5'd0); pc = 32'h40;
      cycle();
    end

    wbw(5'd1, 32'd5); wbw(5'd2, 32'd5); wbw(5'd4, 32'h11);

    // Load-use: lw $2 in EX, add $3,$2,$4 in ID.
    defaults(); valid = 1'b1; ins = rtype(5'd2, 5'd4, 5'd3); exmr = 1'b1; exrw = 1'b1; exrd = 5'd2;
    cycle();
    defaults(); valid = 1'b1; ins = rtype(5'd2, 5'd4, 5'd3); memrw = 1'b1; memrd = 5'd2;
    cycle();

    // beq $1,$2,+3 at PC+4 = 0x100, clean and behind an ALU writer.
    defaults(); valid = 1'b1; pc = 32'h100; ins = itype(6'h04, 5'd1, 5'd2, 16'd3);
    cycle();
    defaults(); valid = 1'b1; pc = 32'h100; ins = itype(6'h04, 5'd1, 5'd2, 16'd3); exrw = 1'b1; exrd = 5'd1;
    cycle();
    defaults(); valid = 1'b1; pc = 32'h100; ins = itype(6'h04, 5'd1, 5'd2, 16'd3); memrw = 1'b1; memrd = 5'd1;
    cycle();
    defaults(); valid = 1'b1; pc = 32'h100; ins = itype(6'h04, 5'd1, 5'd2, 16'd3);
    cycle();

    // Branch behind a load, including its write-back.
    defaults(); valid = 1'b1; pc = 32'h200; ins = itype(6'h05, 5'd1, 5'd4, 16'hFFFE);
    exmr = 1'b1; exrw = 1'b1; exrd = 5'd1;
    cycle();
    defaults(); valid = 1'b1; pc = 32'h200; ins = itype(6'h05, 5'd1, 5'd4, 16'hFFFE); memrw = 1'b1; memrd = 5'd1;
    cycle();
    defaults(); valid = 1'b1; pc = 32'h200; ins = itype(6'h05, 5'd1, 5'd4, 16'hFFFE); rw = 1'b1; rtrd = 5'd1; wd = 32'd5;
    cycle();
    defaults(); valid = 1'b1; pc = 32'h200; ins = itype(6'h05, 5'd1, 5'd4, 16'hFFFE);
    cycle();

    // Write-back collision on $7.
    defaults(); valid = 1'b1; ins = rtype(5'd7, 5'd0, 5'd8); rw = 1'b1; rtrd = 5'd7; wd = 32'hDEADBEEF;
    cycle();
    defaults(); valid = 1'b1; ins = rtype(5'd7, 5'd0, 5'd8);
    cycle();

    // Flush during a load-use stall of a taken beq, then a plain flush.
    defaults(); valid = 1'b1; pc = 32'h100; ins = itype(6'h04, 5'd1, 5'd2, 16'd3); exmr = 1'b1; exrd = 5'd1; flush = 1'b1;
    cycle();
    defaults(); valid = 1'b1; pc = 32'h100; ins = itype(6'h04, 5'd1, 5'd2, 16'd3); flush = 1'b1;
    cycle();

    // Aliasing: $9 folds onto $1 in the 8-register instance.
    wbw(5'd9, 32'h1234);
    defaults(); valid = 1'b1; ins = rtype(5'd1, 5'd9, 5'd3);
    cycle();

    // Randomised traffic; upstream holds the instruction while ID stalls.
    held = 1'b0; cur_ins = 32'h0; cur_pc = 32'h0;
    for (int n = 0; n < 600; n++) begin
      defaults();
      if (!held) begin
        cur_ins = rand_ins();
        cur_pc  = $urandom;
        valid   = ($urandom_range(0, 4) != 0);
      end else begin
        valid = 1'b1;
      end
      ins   = cur_ins; pc = cur_pc;
      flush = ($urandom_range(0, 9) == 0);
      exmr  = ($urandom_range(0, 3) == 0);
      exrw  = exmr || ($urandom_range(0, 2) == 0);
      exrd  = 5'($urandom_range(0, 11));
      memrw = ($urandom_range(0, 2) == 0);
      memrd = 5'($urandom_range(0, 11));
      rw    = ($urandom_range(0, 2) == 0);
      rtrd  = 5'($urandom_range(0, 11));
      wd    = $urandom;
      cycle();
      held = valid && !flush && !last_ready;
    end

    // Reset while stalled; the first cycle afterwards decodes normally.
    defaults(); valid = 1'b1; ins = rtype(5'd2, 5'd3, 5'd4); exmr = 1'b1; exrd = 5'd2;
    cycle();
    do_reset();
    defaults(); valid = 1'b1; ins = rtype(5'd2, 5'd3, 5'd4);
    cycle();

    // Halt followed by an add that must never issue.
    wbw(5'd1, 32'd77);
    defaults(); valid = 1'b1; ins = {6'h3F, 26'd0};
    cycle();
    for (int k = 0; k < 5; k++) begin
      defaults(); valid = 1'b1; ins = rtype(5'd1, 5'd2, 5'd3);
      cycle();
    end

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
